// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch-side types and reset constants for the CPU front end.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Word that the decoder treats as a no-operation.
  localparam logic [31:0] NOP_INSTR = 32'h0320_0000;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // One prefetch queue entry: the fetched word and the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifq_fifo
// Brief    : DEPTH-entry synchronous FIFO of fetch entries with flush.
//            Flush wins over push/pop; push+pop together keep count steady.
// Revision : 1.0 - initial release
// ============================================================================
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  // Next-state pointers and occupancy; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Brief    : Sequential instruction fetcher with credit-limited imem requests,
//            an in-order prefetch queue and branch redirect with stale-response
//            dropping. Build macro IFQ_BYPASS_EN enables a zero-latency path
//            from imem response to decoder when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        halt
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [31:0]   target_aligned;
  logic          gnt_fire, accept, push, pop, bypass, fifo_empty;
  fetch_entry_t  head, push_entry;
  logic          unused_target_lsbs;

  assign target_aligned     = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  // Credits: queued words plus live (non-dropped) in-flight requests may not
  // exceed DEPTH, so every accepted response is guaranteed a free slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q - drop_q};
  assign imem_req    = !rst && !halt && !branch_en
                       && (credit_used < (CW+1)'(DEPTH))
                       && (inflight_q < CW'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign gnt_fire    = imem_req && imem_gnt;

  assign fifo_empty  = (fifo_count == '0);
  assign accept      = imem_rvalid && (drop_q == '0) && !branch_en;
  assign pop         = !fifo_empty && instr_ready && !branch_en;
  assign push_entry  = '{instr: imem_rdata, pc: resp_pc_q};

`ifdef IFQ_BYPASS_EN
  // Empty queue and a live response: hand the word straight to the decoder,
  // and only queue it if the decoder is not taking it this cycle.
  assign bypass = fifo_empty && (drop_q == '0) && imem_rvalid && !branch_en;
  assign push   = accept && !(bypass && instr_ready);
`else
  assign bypass = 1'b0;
  assign push   = accept;
`endif

  // Decoder-facing outputs: queue head, else bypassed response, else NOP.
  always_comb begin
    instr_valid = !fifo_empty || bypass;
    instr       = NOP_INSTR;
    instr_pc    = '0;
    if (!fifo_empty) begin
      instr    = head.instr;
      instr_pc = head.pc;
    end else if (bypass) begin
      instr    = imem_rdata;
      instr_pc = resp_pc_q;
    end
  end

  // Fetch PC, response PC, in-flight and drop accounting; branch has priority.
  always_comb begin
    inflight_d = inflight_q + CW'(gnt_fire) - CW'(imem_rvalid);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    if (branch_en) begin
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
      drop_d     = inflight_d;  // every still-outstanding response is stale
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (accept) resp_pc_d = resp_pc_q + 32'd4;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (branch_en),
    .count     (fifo_count),
    .head      (head)
  );

endmodule
`default_nettype wire
